axi_lite_master_sched: RTL and testbench

Two-port request scheduler in front of the AXI-Lite master wrapper. It shares that one master between the RV32I instruction-fetch port (read-only) and the load/store port (read/write). It allows one outstanding single-beat transaction at a time and drives the wrapper's user read/write request interface. It returns read data or write completion to the requester that won arbitration.

---
 rtl/axi_lite_master_sched.sv | 197 +++++++++++++++++++
 tb/tb_axi_lite_master_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_sched.sv
// Two-port request scheduler in front of the AXI-Lite master wrapper.
// Shares one wrapper between the instruction-fetch port (read-only) and the
// load/store port, with one outstanding single-beat transaction at a time
// and round-robin arbitration between the two requesters.
module axi_lite_master_sched #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = 4,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // instruction-fetch port
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_rdata,
    // load/store port
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    input  logic [STRB_WIDTH-1:0] ls_wstrb,
    output logic                  ls_gnt,
    output logic                  ls_rsp_valid,
    output logic [DATA_WIDTH-1:0] ls_rsp_rdata,
    // wrapper read user port
    output logic                  u_rd_req,
    output logic [ADDR_WIDTH-1:0] u_rd_addr,
    output logic [LEN_WIDTH-1:0]  u_rd_len,
    input  logic                  u_rd_gnt,
    input  logic                  u_rd_wen,
    input  logic [DATA_WIDTH-1:0] u_rd_data,
    output logic                  u_rd_wok,
    // wrapper write user port
    output logic                  u_wr_req,
    output logic [ADDR_WIDTH-1:0] u_wr_addr,
    output logic [LEN_WIDTH-1:0]  u_wr_len,
    output logic [DATA_WIDTH-1:0] u_wr_data,
    output logic [STRB_WIDTH-1:0] u_wr_strb,
    input  logic                  u_wr_gnt,
    input  logic                  u_wr_ren
);

    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_e;
    typedef enum logic {PORT_IF, PORT_LS} port_e;

    state_e                state_q, state_d;
    port_e                 rr_last_q, rr_last_d;
    port_e                 port_q, port_d;
    port_e                 winner;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  aw_now, w_now;
    logic                  if_rsp_valid_q, if_rsp_valid_d;
    logic                  ls_rsp_valid_q, ls_rsp_valid_d;
    logic [DATA_WIDTH-1:0] if_rsp_rdata_q, if_rsp_rdata_d;
    logic [DATA_WIDTH-1:0] ls_rsp_rdata_q, ls_rsp_rdata_d;

    assign if_rsp_valid = if_rsp_valid_q;
    assign ls_rsp_valid = ls_rsp_valid_q;
    assign if_rsp_rdata = if_rsp_rdata_q;
    assign ls_rsp_rdata = ls_rsp_rdata_q;

    // Next-state, arbitration and wrapper-side outputs.
    always_comb begin
        state_d        = state_q;
        rr_last_d      = rr_last_q;
        port_d         = port_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        if_rsp_valid_d = 1'b0;
        ls_rsp_valid_d = 1'b0;
        if_rsp_rdata_d = if_rsp_rdata_q;
        ls_rsp_rdata_d = ls_rsp_rdata_q;
        if_gnt         = 1'b0;
        ls_gnt         = 1'b0;
        u_rd_req       = 1'b0;
        u_rd_addr      = '0;
        u_rd_len       = '0;
        u_rd_wok       = 1'b0;
        u_wr_req       = 1'b0;
        u_wr_addr      = '0;
        u_wr_len       = '0;
        u_wr_data      = '0;
        u_wr_strb      = '0;
        aw_now         = 1'b0;
        w_now          = 1'b0;
        // Fetch wins a tie unless it won last; a lone requester always wins.
        if (if_req && ls_req) begin
            winner = (rr_last_q == PORT_LS) ? PORT_IF : PORT_LS;
        end else begin
            winner = if_req ? PORT_IF : PORT_LS;
        end
        unique case (state_q)
            IDLE: begin
                // Grants are combinational, so keep them low while reset is held.
                if (aresetn && (if_req || ls_req)) begin
                    rr_last_d = winner;
                    port_d    = winner;
                    if (winner == PORT_IF) begin
                        if_gnt  = 1'b1;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        wstrb_d = '0;
                        state_d = RD_ADDR;
                    end else begin
                        ls_gnt  = 1'b1;
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
                        wstrb_d = ls_wstrb;
                        state_d = ls_we ? WR : RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                u_rd_req  = 1'b1;
                u_rd_addr = addr_q;
                u_rd_len  = LEN_WIDTH'(1);
                if (u_rd_gnt) state_d = RD_DATA;
            end
            RD_DATA: begin
                u_rd_wok = 1'b1;
                if (u_rd_wen) begin
                    if (port_q == PORT_IF) begin
                        if_rsp_valid_d = 1'b1;
                        if_rsp_rdata_d = u_rd_data;
                    end else begin
                        ls_rsp_valid_d = 1'b1;
                        ls_rsp_rdata_d = u_rd_data;
                    end
                    state_d = IDLE;
                end
            end
            WR: begin
                u_wr_req  = !aw_done_q;
                u_wr_addr = addr_q;
                u_wr_len  = LEN_WIDTH'(1);
                u_wr_data = wdata_q;
                u_wr_strb = wstrb_q;
                // AW and W acceptance may land in either order or together.
                aw_now    = aw_done_q || (u_wr_req && u_wr_gnt);
                w_now     = w_done_q || u_wr_ren;
                if (aw_now && w_now) begin
                    ls_rsp_valid_d = 1'b1;
                    ls_rsp_rdata_d = '0;
                    aw_done_d      = 1'b0;
                    w_done_d       = 1'b0;
                    state_d        = IDLE;
                end else begin
                    aw_done_d = aw_now;
                    w_done_d  = w_now;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request latch and registered response pulses.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= IDLE;
            rr_last_q      <= PORT_LS;
            port_q         <= PORT_IF;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            if_rsp_rdata_q <= '0;
            ls_rsp_rdata_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_last_q      <= rr_last_d;
            port_q         <= port_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            aw_done_q      <= aw_done_d;
            w_done_q       <= w_done_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            ls_rsp_valid_q <= ls_rsp_valid_d;
            if_rsp_rdata_q <= if_rsp_rdata_d;
            ls_rsp_rdata_q <= ls_rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master_sched.sv
// Scoreboard bench for axi_lite_master_sched: request drivers push expected
// responses at grant time, a negedge monitor pops and compares them, and a
// reactive wrapper model answers the user read/write ports.
module tb_axi_lite_master_sched;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        if_req, if_gnt, if_rsp_valid;
    logic [31:0] if_addr, if_rsp_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rsp_valid;
    logic [31:0] ls_addr, ls_wdata, ls_rsp_rdata;
    logic [3:0]  ls_wstrb;
    logic        u_rd_req, u_rd_gnt, u_rd_wen, u_rd_wok;
    logic [31:0] u_rd_addr, u_rd_data;
    logic [7:0]  u_rd_len;
    logic        u_wr_req, u_wr_gnt, u_wr_ren;
    logic [31:0] u_wr_addr, u_wr_data;
    logic [7:0]  u_wr_len;
    logic [3:0]  u_wr_strb;

    axi_lite_master_sched #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .LEN_WIDTH(8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
        .u_rd_req(u_rd_req), .u_rd_addr(u_rd_addr), .u_rd_len(u_rd_len),
        .u_rd_gnt(u_rd_gnt), .u_rd_wen(u_rd_wen), .u_rd_data(u_rd_data),
        .u_rd_wok(u_rd_wok),
        .u_wr_req(u_wr_req), .u_wr_addr(u_wr_addr), .u_wr_len(u_wr_len),
        .u_wr_data(u_wr_data), .u_wr_strb(u_wr_strb),
        .u_wr_gnt(u_wr_gnt), .u_wr_ren(u_wr_ren)
    );

    always #5 aclk = ~aclk;

    typedef struct { bit port; logic [31:0] data; int due; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;

    rsp_t exp_q[$];
    wr_t  wr_exp_q[$];
    bit   gnt_log[$];
    int   ncmp = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   rd_ar_cyc = -1;
    bit   rd_hold = 1'b0;
    int   wr_aw_d = 0;
    int   wr_w_d = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        ncmp++;
        nerr++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Slave read data: fixed word for the boot fetch, otherwise address-derived.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
    endfunction

    // Wrapper read side: zero-wait AR, data on first wok cycle unless held.
    initial begin : rd_slave
        logic [31:0] cap;
        u_rd_gnt = 1'b0; u_rd_wen = 1'b0; u_rd_data = '0; cap = '0;
        forever begin
            @(negedge aclk);
            u_rd_gnt = u_rd_req;
            if (u_rd_req) begin
                cap = u_rd_addr;
                rd_ar_cyc = cyc;
                check("rd_len", u_rd_len, 1);
            end
            u_rd_wen = u_rd_wok && !rd_hold;
            if (u_rd_wen) u_rd_data = mem_word(cap);
        end
    end

    // Wrapper write side: AW and W accepted wr_aw_d / wr_w_d cycles into WR.
    initial begin : wr_slave
        int  t;
        bit  in_wr, w_seen, aw_prev;
        wr_t w;
        t = 0; in_wr = 0; w_seen = 0; aw_prev = 0;
        u_wr_gnt = 1'b0; u_wr_ren = 1'b0;
        forever begin
            @(negedge aclk);
            u_wr_gnt = 1'b0; u_wr_ren = 1'b0;
            if (u_wr_len != 0) begin
                if (!in_wr) begin in_wr = 1; t = 0; end else t++;
                if (aw_prev) check("wr_req_drop", u_wr_req, 0);
                u_wr_gnt = u_wr_req && (t >= wr_aw_d);
                aw_prev = u_wr_gnt;
                if (!w_seen && t >= wr_w_d) begin
                    u_wr_ren = 1'b1;
                    w_seen = 1;
                    if (wr_exp_q.size() == 0) begin
                        timeout("wr_unexpected_beat");
                    end else begin
                        w = wr_exp_q.pop_front();
                        check("wr_addr", u_wr_addr, w.addr);
                        check("wr_data", u_wr_data, w.data);
                        check("wr_strb", u_wr_strb, w.strb);
                        check("wr_len", u_wr_len, 1);
                    end
                end
            end else begin
                in_wr = 0; w_seen = 0; aw_prev = 0;
            end
        end
    end

    // Response monitor: pops the oldest expectation on every pulse.
    rsp_t mon_e;
    always @(negedge aclk) begin
        if (if_rsp_valid || ls_rsp_valid) begin
            check("rsp_one_port", {if_rsp_valid, ls_rsp_valid} == 2'b11, 0);
            if (exp_q.size() == 0) begin
                timeout("rsp_unexpected");
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_port", ls_rsp_valid, mon_e.port);
                check("rsp_data", ls_rsp_valid ? ls_rsp_rdata : if_rsp_rdata, mon_e.data);
                check("rsp_cycle", cyc, mon_e.due);
            end
        end
    end

    task automatic if_txn(input logic [31:0] a, input logic [31:0] exp, input int lat,
                          output int g);
        int n;
        if_req = 1'b1; if_addr = a; n = 0; g = -1;
        do begin @(negedge aclk); n++; end while (!if_gnt && n < 100);
        if (!if_gnt) timeout("if_gnt");
        else begin
            g = cyc;
            exp_q.push_back('{1'b0, exp, cyc + lat});
            gnt_log.push_back(1'b0);
        end
        @(posedge aclk); #1;
        if_req = 1'b0; if_addr = '0;
    endtask

    task automatic ls_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic [31:0] exp, input int lat,
                          output int g);
        int n;
        ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd; ls_wstrb = st;
        n = 0; g = -1;
        do begin @(negedge aclk); n++; end while (!ls_gnt && n < 100);
        if (!ls_gnt) timeout("ls_gnt");
        else begin
            g = cyc;
            exp_q.push_back('{1'b1, exp, cyc + lat});
            if (we) wr_exp_q.push_back('{a, wd, st});
            gnt_log.push_back(1'b1);
        end
        @(posedge aclk); #1;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_exp_q.size() != 0) && n < 50) begin
            @(posedge aclk); n++;
        end
        if (n >= 50) timeout("drain");
        @(posedge aclk); #1;
    endtask

    function automatic bit outs_nonzero();
        return ({if_gnt, if_rsp_valid, if_rsp_rdata, ls_gnt, ls_rsp_valid, ls_rsp_rdata,
                 u_rd_req, u_rd_addr, u_rd_len, u_rd_wok, u_wr_req, u_wr_addr,
                 u_wr_len, u_wr_data, u_wr_strb} !== '0);
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int g, g1, g2;
        aresetn = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
        #1;
        check("reset_outputs", outs_nonzero(), 0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;

        // Single fetch, zero-wait slave.
        if_txn(32'h0000_0100, 32'h0000_0013, 3, g);
        drain();
        check("t1_ar_cycle", rd_ar_cyc, g + 1);

        // Back-to-back loads: second grant lands on the first response cycle.
        ls_txn(1'b0, 32'h3000_0000, '0, '0, 32'h95A5_0000, 3, g1);
        ls_txn(1'b0, 32'h3000_0008, '0, '0, 32'h95A5_0008, 3, g2);
        check("b2b_gnt_cycle", g2, g1 + 3);
        drain();

        // Store, W accepted two cycles after AW.
        wr_aw_d = 0; wr_w_d = 2;
        ls_txn(1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 4, g);
        drain();

        // Store, AW and W in the same cycle.
        wr_aw_d = 0; wr_w_d = 0;
        ls_txn(1'b1, 32'h2000_0008, 32'h1234_5678, 4'h3, 32'h0, 2, g);
        drain();

        // Store, W accepted before AW.
        wr_aw_d = 2; wr_w_d = 0;
        ls_txn(1'b1, 32'h2000_000C, 32'hCAFE_F00D, 4'h8, 32'h0, 4, g);
        drain();
        wr_aw_d = 0;

        // Both requesters held from reset: fetch first, then alternate.
        aresetn = 1'b0;
        exp_q.delete(); wr_exp_q.delete(); gnt_log.delete();
        if_req = 1'b1; if_addr = 32'h0000_0200;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h1000_0000;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        fork
            begin
                int ga;
                if_txn(32'h0000_0200, 32'hA5A5_0200, 3, ga);
                if_txn(32'h0000_0204, 32'hA5A5_0204, 3, ga);
            end
            begin
                int gb;
                ls_txn(1'b0, 32'h1000_0000, '0, '0, 32'hB5A5_0000, 3, gb);
                ls_txn(1'b0, 32'h1000_0004, '0, '0, 32'hB5A5_0004, 3, gb);
            end
        join
        drain();
        check("rr_count", gnt_log.size(), 4);
        if (gnt_log.size() == 4) begin
            check("rr_gnt0", gnt_log[0], 0);
            check("rr_gnt1", gnt_log[1], 1);
            check("rr_gnt2", gnt_log[2], 0);
            check("rr_gnt3", gnt_log[3], 1);
        end

        // Reset while waiting in RD_DATA: abandoned, no response.
        rd_hold = 1'b1;
        if_txn(32'h0000_0300, 32'hA5A5_0300, 3, g);
        g1 = 0;
        while (!u_rd_wok && g1 < 10) begin @(negedge aclk); g1++; end
        check("mid_rd_data_reached", u_rd_wok, 1);
        #2 aresetn = 1'b0;
        exp_q.delete();
        #1;
        check("mid_reset_outputs", outs_nonzero(), 0);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        rd_hold = 1'b0;
        if_txn(32'h0000_0300, 32'hA5A5_0300, 3, g);
        drain();

        check("final_exp_empty", exp_q.size(), 0);
        check("final_wr_empty", wr_exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
